// File: rtl/mem_access_ctrl_if.sv
// Word-addressed RAM request/acknowledge bus between the MDR front end and the memory.
// The controller drives the request side; the RAM drives the ack side.
interface mem_access_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-side front end of the MDR: runs one read or write per command over a req/ack RAM bus,
// with an ack timeout and an address range check. All outputs are registered.
module mem_access_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start_read,
  input  logic              start_write,
  input  logic [31:0]       addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] Mdatain,
  output logic              Read,
  mem_access_ctrl_if.master mem
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e            state_q;
  logic [7:0]        cnt_q;
  logic              busy_q, done_q, err_q, read_q;
  logic              req_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, mdata_q;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      read_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      read_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          err_q <= 1'b0;
          if (start_read || start_write) begin
            addr_q  <= addr_in[ADDR_W-1:0];
            wdata_q <= wdata_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            if (addr_in[31:ADDR_W] != '0) begin
              // Out-of-range address never reaches the RAM.
              state_q <= StDone;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= StAccess;
              req_q   <= 1'b1;
              we_q    <= ~start_read;  // read wins a collision
            end
          end
        end
        StAccess: begin
          if (mem.mem_ack) begin
            if (!we_q) begin
              mdata_q <= mem.mem_rdata;
              read_q  <= 1'b1;
            end
            state_q <= StDone;
            done_q  <= 1'b1;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
          end else if (cnt_q == 8'(TIMEOUT - 1)) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign Read          = read_q;
  assign Mdatain       = mdata_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a small RAM model that acks
// after a configurable number of wait cycles.
module tb_mem_access_ctrl;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned TIMEOUT = 15;

  logic              clock = 1'b0;
  logic              clear = 1'b0;
  logic              start_read = 1'b0;
  logic              start_write = 1'b0;
  logic [31:0]       addr_in = '0;
  logic [DATA_W-1:0] wdata_in = '0;
  logic              busy, done, err, Read;
  logic [DATA_W-1:0] Mdatain;

  int n_tests = 0;
  int n_fail  = 0;

  // RAM model controls
  int   wait_cfg = 0;
  logic ack_en   = 1'b1;
  int   wcnt;
  logic [DATA_W-1:0] ram [2**ADDR_W];

  mem_access_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mif ();

  mem_access_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock      (clock),
    .clear      (clear),
    .start_read (start_read),
    .start_write(start_write),
    .addr_in    (addr_in),
    .wdata_in   (wdata_in),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .Mdatain    (Mdatain),
    .Read       (Read),
    .mem        (mif.master)
  );

  always #5 clock = ~clock;

  assign mif.mem_ack   = ack_en && mif.mem_req && (wcnt == wait_cfg);
  assign mif.mem_rdata = ram[mif.mem_addr];

  always @(posedge clock or negedge clear) begin
    if (!clear) begin
      wcnt <= 0;
      for (int i = 0; i < 2**ADDR_W; i++) ram[i] <= 32'(i);
      ram[5] <= 32'hAAAA_AAAA;
      ram[6] <= 32'h0BAD_F00D;
      ram[7] <= 32'h0000_0000;
    end else begin
      if (!mif.mem_req || mif.mem_ack) wcnt <= 0;
      else wcnt <= wcnt + 1;
      if (mif.mem_req && mif.mem_ack && mif.mem_we) ram[mif.mem_addr] <= mif.mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Step past the next rising edge so outputs are sampled and inputs driven away from it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int n_cyc, n_hi, n_done;

  initial begin
    // Reset state
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_req", 32'(mif.mem_req), 32'd0);
    check("rst_mdatain", Mdatain, 32'd0);
    #10 clear = 1'b1;
    tick();

    // T2: zero-wait read of address 5
    wait_cfg = 0; ack_en = 1'b1;
    start_read = 1'b1; addr_in = 32'd5;
    tick();
    start_read = 1'b0;
    check("t2_req", 32'(mif.mem_req), 32'd1);
    check("t2_we", 32'(mif.mem_we), 32'd0);
    check("t2_busy", 32'(busy), 32'd1);
    check("t2_done_early", 32'(done), 32'd0);
    tick();
    check("t2_done", 32'(done), 32'd1);
    check("t2_read", 32'(Read), 32'd1);
    check("t2_err", 32'(err), 32'd0);
    check("t2_mdatain", Mdatain, 32'hAAAA_AAAA);
    check("t2_req_drop", 32'(mif.mem_req), 32'd0);
    tick();
    check("t2_idle_done", 32'(done), 32'd0);
    check("t2_idle_busy", 32'(busy), 32'd0);

    // T3: write with three wait cycles
    wait_cfg = 3;
    start_write = 1'b1; addr_in = 32'd7; wdata_in = 32'h5555_5555;
    tick();
    start_write = 1'b0;
    n_cyc = 0; n_hi = 0;
    while (!done && n_cyc < 40) begin
      if (mif.mem_we) n_hi++;
      tick();
      n_cyc++;
    end
    check("t3_we_cycles", 32'(n_hi), 32'd4);
    check("t3_done", 32'(done), 32'd1);
    check("t3_read", 32'(Read), 32'd0);
    check("t3_err", 32'(err), 32'd0);
    check("t3_ram", ram[7], 32'h5555_5555);
    tick();

    // T4: timeout with ack tied low
    ack_en = 1'b0;
    start_read = 1'b1; addr_in = 32'd5;
    tick();
    start_read = 1'b0;
    n_cyc = 0; n_hi = 0;
    while (!done && n_cyc < 40) begin
      if (mif.mem_req) n_hi++;
      tick();
      n_cyc++;
    end
    check("t4_req_cycles", 32'(n_hi), 32'(TIMEOUT));
    check("t4_done", 32'(done), 32'd1);
    check("t4_err", 32'(err), 32'd1);
    check("t4_read", 32'(Read), 32'd0);
    check("t4_mdatain", Mdatain, 32'hAAAA_AAAA);
    tick();
    ack_en = 1'b1;

    // T5: out-of-range address
    wait_cfg = 0;
    start_read = 1'b1; addr_in = 32'h200;
    tick();
    start_read = 1'b0;
    check("t5_req", 32'(mif.mem_req), 32'd0);
    check("t5_done", 32'(done), 32'd1);
    check("t5_err", 32'(err), 32'd1);
    check("t5_read", 32'(Read), 32'd0);
    tick();

    // T6a: simultaneous read and write -> read only
    start_read = 1'b1; start_write = 1'b1; addr_in = 32'd5; wdata_in = 32'h1234_5678;
    tick();
    start_read = 1'b0; start_write = 1'b0;
    check("t6_we", 32'(mif.mem_we), 32'd0);
    check("t6_req", 32'(mif.mem_req), 32'd1);
    tick();
    check("t6_read", 32'(Read), 32'd1);
    check("t6_ram_kept", ram[5], 32'hAAAA_AAAA);
    tick();

    // T6b: start held through ACCESS and DONE is ignored
    wait_cfg = 2;
    start_read = 1'b1; addr_in = 32'd6;
    tick();
    addr_in = 32'd7;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        n_done++;
        start_read = 1'b0;
      end
      tick();
    end
    start_read = 1'b0;
    check("t6_one_done", 32'(n_done), 32'd1);
    check("t6_mdatain", Mdatain, 32'h0BAD_F00D);
    check("t6_idle", 32'(busy), 32'd0);

    // T1: reset in the middle of an access
    ack_en = 1'b0;
    start_read = 1'b1; addr_in = 32'd5;
    tick();
    start_read = 1'b0;
    tick();
    check("t1_req_pre", 32'(mif.mem_req), 32'd1);
    #2 clear = 1'b0;
    #1;
    check("t1_req", 32'(mif.mem_req), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_done", 32'(done), 32'd0);
    check("t1_read", 32'(Read), 32'd0);
    check("t1_mdatain", Mdatain, 32'd0);
    tick();
    clear = 1'b1;
    ack_en = 1'b1;
    tick();
    check("t1_no_done", 32'(done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
